leitor_display: RTL and testbench

LEITOR_DISPLAY -- requirements
Module: leitor_display

---
 rtl/leitor_display.sv | 118 +++++++++++
 tb/tb_leitor_display.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/leitor_display.sv
// Captures a multiplexed, active-low 7-segment display bus.
// A digit is decoded only after the bus has held steady for STABLE_CYCLES edges.
module leitor_display #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  anodos,
    input  logic [0:6]  segmentos,
    output logic [15:0] digitos,
    output logic [3:0]  validos,
    output logic [3:0]  erros,
    output logic        novo,
    output logic        quadro
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [10:0] r_prev;
    logic [7:0]  r_cnt;
    logic [3:0]  r_mask;

    logic [10:0] w_in;
    logic        w_same;
    logic [7:0]  w_cntNext;
    logic [3:0]  w_sel;
    logic        w_oneLow;
    logic        w_capture;
    logic [1:0]  w_idx;
    logic [3:0]  w_value;
    logic        w_valid;
    logic        w_err;
    logic [3:0]  w_maskNext;
    logic        w_frameDone;

    assign w_in   = {anodos, segmentos};
    assign w_same = (w_in == r_prev);
    assign w_sel  = ~anodos;

    // Exactly one anode low: nonzero select with a single bit set.
    assign w_oneLow = (w_sel != 4'b0000) && ((w_sel & (w_sel - 4'd1)) == 4'b0000);

    always_comb begin
        w_cntNext = 8'd1;
        if (w_same) begin
            w_cntNext = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 8'd1;
        end
    end

    // The crossing into CNT_MAX happens once per held pattern, giving a single capture.
    assign w_capture = w_same && (r_cnt == CNT_MAX - 8'd1) && w_oneLow;

    always_comb begin
        w_idx = 2'd0;
        case (anodos)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_value = 4'hE;
        w_valid = 1'b1;
        w_err   = 1'b0;
        case (segmentos)
            7'b0000001: w_value = 4'd0;
            7'b1001111: w_value = 4'd1;
            7'b0010010: w_value = 4'd2;
            7'b0000110: w_value = 4'd3;
            7'b1001100: w_value = 4'd4;
            7'b0100100: w_value = 4'd5;
            7'b0100000: w_value = 4'd6;
            7'b0001111: w_value = 4'd7;
            7'b0000000: w_value = 4'd8;
            7'b0000100: w_value = 4'd9;
            7'b1111111: begin
                w_value = 4'hF;
                w_valid = 1'b0;
            end
            default: begin
                w_value = 4'hE;
                w_valid = 1'b0;
                w_err   = 1'b1;
            end
        endcase
    end

    assign w_maskNext  = r_mask | w_sel;
    assign w_frameDone = (w_maskNext == 4'b1111);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev  <= '1;
            r_cnt   <= 8'd0;
            r_mask  <= 4'b0000;
            digitos <= 16'hFFFF;
            validos <= 4'b0000;
            erros   <= 4'b0000;
            novo    <= 1'b0;
            quadro  <= 1'b0;
        end else begin
            r_prev <= w_in;
            r_cnt  <= w_cntNext;
            novo   <= w_capture;
            quadro <= w_capture && w_frameDone;
            if (w_capture) begin
                digitos[{w_idx, 2'b00} +: 4] <= w_value;
                validos[w_idx]               <= w_valid;
                erros[w_idx]                 <= w_err;
                r_mask <= w_frameDone ? 4'b0000 : w_maskNext;
            end
        end
    end

endmodule

// File: tb/tb_leitor_display.sv
// Scoreboard bench for leitor_display: a behavioural model predicts every
// capture, and a negedge monitor matches each novo pulse against it.
module tb_leitor_display;

   localparam int S = 4;

   typedef struct {
      logic [15:0] dig;
      logic [3:0]  val;
      logic [3:0]  err;
      logic        quad;
   } expT;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  anodos = 4'b1111;
   logic [0:6]  segmentos = 7'b1111111;
   logic [15:0] digitos;
   logic [3:0]  validos;
   logic [3:0]  erros;
   logic        novo;
   logic        quadro;

   expT expQ[$];
   int checkCount = 0;
   int passCount  = 0;
   int novoSeen   = 0;
   int novoPushed = 0;

   logic [15:0] mDig  = 16'hFFFF;
   logic [3:0]  mVal  = 4'b0000;
   logic [3:0]  mErr  = 4'b0000;
   logic [3:0]  mMask = 4'b0000;

   leitor_display #(.STABLE_CYCLES(S)) dut (
      .clock(clock),
      .reset(reset),
      .anodos(anodos),
      .segmentos(segmentos),
      .digitos(digitos),
      .validos(validos),
      .erros(erros),
      .novo(novo),
      .quadro(quadro)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   // Reference decode of an a..g active-low pattern; F = blank, E = unrecognised.
   function automatic logic [3:0] expVal(input logic [6:0] s);
      case (s)
         7'b0000001: return 4'd0;
         7'b1001111: return 4'd1;
         7'b0010010: return 4'd2;
         7'b0000110: return 4'd3;
         7'b1001100: return 4'd4;
         7'b0100100: return 4'd5;
         7'b0100000: return 4'd6;
         7'b0001111: return 4'd7;
         7'b0000000: return 4'd8;
         7'b0000100: return 4'd9;
         7'b1111111: return 4'hF;
         default:    return 4'hE;
      endcase
   endfunction

   // Drives one pattern for nEdges rising edges and predicts whether it captures.
   task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int nEdges);
      int idx;
      logic [3:0] v;
      expT e;
      anodos    = an;
      segmentos = seg;
      idx = -1;
      case (an)
         4'b1110: idx = 0;
         4'b1101: idx = 1;
         4'b1011: idx = 2;
         4'b0111: idx = 3;
         default: idx = -1;
      endcase
      if (nEdges >= S && idx >= 0) begin
         v = expVal(seg);
         mDig[idx*4 +: 4] = v;
         mVal[idx] = (v <= 4'd9);
         mErr[idx] = (v == 4'hE);
         mMask[idx] = 1'b1;
         e.dig  = mDig;
         e.val  = mVal;
         e.err  = mErr;
         e.quad = (mMask == 4'b1111);
         if (e.quad) mMask = 4'b0000;
         expQ.push_back(e);
         novoPushed++;
      end
      repeat (nEdges) @(posedge clock);
      #1;
   endtask

   task automatic pulseReset(input int nEdges);
      reset = 1'b1;
      repeat (nEdges) @(posedge clock);
      #1;
      reset = 1'b0;
      mDig  = 16'hFFFF;
      mVal  = 4'b0000;
      mErr  = 4'b0000;
      mMask = 4'b0000;
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_digitos"}, 32'(digitos), 32'(mDig));
      checkOutput({tag, "_validos"}, 32'(validos), 32'(mVal));
      checkOutput({tag, "_erros"}, 32'(erros), 32'(mErr));
   endtask

   // Monitor: each novo must match the oldest predicted capture.
   always @(negedge clock) begin
      if (novo) begin
         expT e;
         novoSeen++;
         if (expQ.size() == 0) begin
            checkOutput("novoUnexpected", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("capDigitos", 32'(digitos), 32'(e.dig));
            checkOutput("capValidos", 32'(validos), 32'(e.val));
            checkOutput("capErros", 32'(erros), 32'(e.err));
            checkOutput("capQuadro", 32'(quadro), 32'(e.quad));
         end
      end else if (quadro) begin
         checkOutput("quadroWithoutNovo", 32'd1, 32'd0);
      end
   end

   initial begin
      pulseReset(2);
      checkState("reset");
      checkOutput("reset_novo", 32'(novo), 32'd0);
      checkOutput("reset_quadro", 32'(quadro), 32'd0);

      applyStimulus(4'b1110, 7'b0010010, 4);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkState("digit2");

      applyStimulus(4'b1110, 7'b1001111, 4);
      applyStimulus(4'b1101, 7'b0000110, 4);
      applyStimulus(4'b1011, 7'b1001100, 4);
      applyStimulus(4'b0111, 7'b0000000, 4);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkState("scan");
      checkOutput("scan_value", 32'(digitos), 32'h8431);

      applyStimulus(4'b1011, 7'b1111110, 4);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkState("illegal");
      applyStimulus(4'b1011, 7'b1111111, 4);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkState("blank");

      for (int i = 0; i < 6; i++)
         applyStimulus(4'b1110, (i % 2 == 0) ? 7'b0100000 : 7'b0100100, 3);
      applyStimulus(4'b1100, 7'b0000000, 10);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkState("noCapture");

      pulseReset(1);
      applyStimulus(4'b1110, 7'b0100100, 4);
      applyStimulus(4'b1101, 7'b0001111, 4);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkState("partial");
      pulseReset(1);
      checkState("midReset");
      checkOutput("midReset_digitos", 32'(digitos), 32'hFFFF);
      applyStimulus(4'b1011, 7'b0000100, 4);
      applyStimulus(4'b0111, 7'b0100000, 4);
      applyStimulus(4'b1111, 7'b1111111, 2);
      checkState("afterReset");

      applyStimulus(4'b1101, 7'b0100100, 20);
      applyStimulus(4'b1111, 7'b1111111, 3);
      checkState("longHold");

      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
      checkOutput("novoCount", 32'(novoSeen), 32'(novoPushed));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
